// File: rtl/memory_arbiter.sv
// Two-port (fetch/data) arbiter and sequencer in front of the single-port Memory block.
// Define MEM_ARB_ROUND_ROBIN_EN for round-robin grants; otherwise port 1 has fixed priority.
module memory_arbiter #(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int WAIT_STATES = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  m0_req,
  input  logic                  m0_we,
  input  logic [ADDR_WIDTH-1:0] m0_addr,
  input  logic [DATA_WIDTH-1:0] m0_wdata,
  output logic                  m0_ack,
  output logic [DATA_WIDTH-1:0] m0_rdata,
  input  logic                  m1_req,
  input  logic                  m1_we,
  input  logic [ADDR_WIDTH-1:0] m1_addr,
  input  logic [DATA_WIDTH-1:0] m1_wdata,
  output logic                  m1_ack,
  output logic [DATA_WIDTH-1:0] m1_rdata,
  output logic                  memory_read,
  output logic                  memory_write,
  output logic [ADDR_WIDTH-1:0] address,
  output logic [DATA_WIDTH-1:0] write_data,
  input  logic [DATA_WIDTH-1:0] read_data,
  output logic                  busy
);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  localparam logic [3:0] WS_INIT = 4'(WAIT_STATES);

  state_t                  state, state_nxt;
  logic [3:0]              cnt;
  logic                    id_q, we_q;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [DATA_WIDTH-1:0]   wdata_q;
  logic                    any_req, grant;

  assign any_req = m0_req | m1_req;

`ifdef MEM_ARB_ROUND_ROBIN_EN
  logic last_grant;

  // Contested round goes to whichever port was not granted last
  assign grant = (m0_req & m1_req) ? ~last_grant : m1_req;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      last_grant <= 1'b1;
    else if (state == IDLE && any_req)
      last_grant <= grant;
  end
`else
  assign grant = m1_req;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      cnt      <= '0;
      id_q     <= 1'b0;
      we_q     <= 1'b0;
      m0_rdata <= '0;
      m1_rdata <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (any_req) begin
            id_q <= grant;
            we_q <= grant ? m1_we : m0_we;
            cnt  <= WS_INIT;
          end
        end
        ACCESS: begin
          if (cnt != 4'd0)
            cnt <= cnt - 4'd1;
          else if (!we_q) begin
            if (id_q) m1_rdata <= read_data;
            else      m0_rdata <= read_data;
          end
        end
        default: ;
      endcase
    end
  end

  // Address/data copies only matter while in ACCESS, so they carry no reset
  always_ff @(posedge clk) begin
    if (state == IDLE && any_req) begin
      addr_q  <= grant ? m1_addr  : m0_addr;
      wdata_q <= grant ? m1_wdata : m0_wdata;
    end
  end

  always_comb begin
    state_nxt    = state;
    memory_read  = 1'b0;
    memory_write = 1'b0;
    address      = '0;
    write_data   = '0;
    m0_ack       = 1'b0;
    m1_ack       = 1'b0;
    busy         = 1'b0;
    case (state)
      IDLE: begin
        if (any_req) state_nxt = ACCESS;
      end
      ACCESS: begin
        busy         = 1'b1;
        memory_read  = ~we_q;
        memory_write = we_q;
        address      = addr_q;
        write_data   = wdata_q;
        if (cnt == 4'd0) state_nxt = DONE;
      end
      DONE: begin
        busy      = 1'b1;
        m0_ack    = ~id_q;
        m1_ack    = id_q;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule
